// File: rtl/apb_gpio_subordinate_if.sv
// APB bus bundle between the manager slot and the GPIO subordinate.
// Carries no clock/reset; those stay plain ports on the modules.
interface apb_gpio_subordinate_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_gpio_subordinate.sv
// APB GPIO register file (CR/ODR/IDR, plus IER/ISR edge interrupt when GPIO_IRQ_EN is defined).
// Latency: one wait state per transfer (SETUP, ACCESS1, ACCESS2); inputs reach IDR after 2 PCLK edges.
// Backpressure: PREADY is low for exactly one access cycle per transfer; back-to-back transfers need no idle.
module apb_gpio_subordinate #(
    parameter int WIDTH = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_gpio_subordinate_if.slave apb,
    input  logic [WIDTH-1:0]     gpio_in,
    output logic [WIDTH-1:0]     gpio_out,
    output logic [WIDTH-1:0]     gpio_oe,
    output logic                 irq
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cr_q, odr_q;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [31:0]      prdata_q;
    logic             pready_q;
    logic [31:0]      rd_data;
    logic [2:0]       reg_sel;
    logic [WIDTH-1:0] wdat;
    logic             xfer_start;
    logic             wr_commit;

    assign reg_sel    = apb.PADDR[4:2];
    assign wdat       = apb.PWDATA[WIDTH-1:0];
    assign xfer_start = (state_q == IDLE) && apb.PSEL && apb.PENABLE;
    // Writes land on the edge that leaves ACK, so a reset during ACCESS1 drops them.
    assign wr_commit  = (state_q == ACK) && apb.PSEL && apb.PWRITE;

    logic unused_apb;
    assign unused_apb = ^{apb.PADDR[31:5], apb.PADDR[1:0], apb.PWDATA};

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (apb.PSEL && apb.PENABLE) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cr_q  <= '0;
            odr_q <= '0;
        end else if (wr_commit) begin
            if (reg_sel == 3'd0) cr_q  <= wdat;
            if (reg_sel == 3'd1) odr_q <= wdat;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] ier_q, isr_q, prev_q, rise;
    logic             irq_q;

    assign rise = sync2_q & ~prev_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            prev_q <= '0;
            ier_q  <= '0;
            isr_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= sync2_q;
            if (wr_commit && reg_sel == 3'd3) ier_q <= wdat;
            // A new edge on the same bit as a W1C keeps the flag set.
            if (wr_commit && reg_sel == 3'd4)
                isr_q <= (isr_q & ~wdat) | (rise & ier_q);
            else
                isr_q <= isr_q | (rise & ier_q);
            irq_q  <= |isr_q;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            3'd0: rd_data[WIDTH-1:0] = cr_q;
            3'd1: rd_data[WIDTH-1:0] = odr_q;
            3'd2: rd_data[WIDTH-1:0] = sync2_q;
`ifdef GPIO_IRQ_EN
            3'd3: rd_data[WIDTH-1:0] = ier_q;
            3'd4: rd_data[WIDTH-1:0] = isr_q;
`endif
            default: rd_data = '0;
        endcase
    end

    // PRDATA only holds a value during ACK; it is zero in every other cycle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            prdata_q <= '0;
            pready_q <= 1'b0;
        end else begin
            prdata_q <= (xfer_start && !apb.PWRITE) ? rd_data : 32'd0;
            pready_q <= (state_d == ACK);
        end
    end

    assign apb.PRDATA = prdata_q;
    assign apb.PREADY = pready_q;
    assign gpio_oe    = cr_q;
    assign gpio_out   = odr_q & cr_q;

endmodule

// File: tb/tb_apb_gpio_subordinate.sv
// Directed bench for apb_gpio_subordinate; IRQ steps are included when GPIO_IRQ_EN is defined.
module tb_apb_gpio_subordinate;
    localparam int WIDTH = 8;

    logic             PCLK;
    logic             PRESET;
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
    logic             irq;
    int               checks;
    int               errors;
    logic [31:0]      rdata;

    apb_gpio_subordinate_if bus ();

    apb_gpio_subordinate #(.WIDTH(WIDTH)) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .apb      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives SETUP, ACCESS1, ACCESS2 and returns at the
    // negedge after ACCESS2 with the bus idle, so a following call is back-to-back.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd);
        logic [2:0] rdy;
        rdy[2]      = bus.PREADY;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wdata;
        @(negedge PCLK);
        rdy[1]      = bus.PREADY;
        bus.PENABLE = 1'b1;
        @(negedge PCLK);
        rdy[0]      = bus.PREADY;
        rd          = bus.PRDATA;
        check("pready_pattern", {29'd0, rdy}, 32'h0000_0001);
        @(negedge PCLK);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        xfer(1'b1, addr, data, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        xfer(1'b0, addr, 32'hDEAD_BEEF, r);
        check(tag, r, exp);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        PRESET      = 1'b1;
        gpio_in     = '0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;

        check("rst_pready", {31'd0, bus.PREADY}, 32'd0);
        check("rst_prdata", bus.PRDATA, 32'd0);
        check("rst_gpio_oe", {24'd0, gpio_oe}, 32'd0);
        check("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        for (int i = 0; i < 8; i++)
            rd_check("rst_read_offset", 32'h1000_1000 + 32'(i * 4), 32'd0);

        wr_reg(32'h1000_1000, 32'h0000_000F);
        wr_reg(32'h1000_1004, 32'h0000_00FF);
        check("cr_oe", {24'd0, gpio_oe}, 32'h0F);
        check("odr_out_masked", {24'd0, gpio_out}, 32'h0F);
        rd_check("odr_read", 32'h1000_1007, 32'h0000_00FF);
        rd_check("cr_read", 32'h1000_1001, 32'h0000_000F);

        gpio_in = 8'hA5;
        repeat (3) @(negedge PCLK);
        rd_check("idr_read", 32'h1000_1008, 32'h0000_00A5);
        wr_reg(32'h1000_1008, 32'h0000_0012);
        rd_check("idr_ro", 32'h1000_1008, 32'h0000_00A5);

        wr_reg(32'h1000_1004, 32'h0000_003C);
        rd_check("b2b_odr", 32'h1000_1004, 32'h0000_003C);
        check("b2b_gpio_out", {24'd0, gpio_out}, 32'h0C);

        wr_reg(32'h1000_1004, 32'hFFFF_FF55);
        rd_check("odr_upper_ignored", 32'h1000_1004, 32'h0000_0055);

        wr_reg(32'h1000_1014, 32'hFFFF_FFFF);
        rd_check("unmapped_5", 32'h1000_1014, 32'd0);
        wr_reg(32'h1000_101C, 32'hFFFF_FFFF);
        rd_check("unmapped_7", 32'h1000_101C, 32'd0);

`ifdef GPIO_IRQ_EN
        gpio_in = 8'hA4;
        repeat (4) @(negedge PCLK);
        wr_reg(32'h1000_100C, 32'h0000_0001);
        rd_check("ier_read", 32'h1000_100C, 32'h0000_0001);
        rd_check("isr_idle", 32'h1000_1010, 32'd0);
        gpio_in = 8'hA5;
        repeat (4) @(negedge PCLK);
        check("irq_set", {31'd0, irq}, 32'd1);
        rd_check("isr_set", 32'h1000_1010, 32'h0000_0001);
        wr_reg(32'h1000_1010, 32'h0000_0001);
        @(negedge PCLK);
        check("irq_clear", {31'd0, irq}, 32'd0);
        rd_check("isr_cleared", 32'h1000_1010, 32'd0);

        gpio_in = 8'hA4;
        repeat (4) @(negedge PCLK);
        wr_reg(32'h1000_1010, 32'h0000_0001);
        gpio_in = 8'hA5;
        wr_reg(32'h1000_1010, 32'h0000_0001);
        rd_check("isr_set_wins", 32'h1000_1010, 32'h0000_0001);
        check("irq_set_wins", {31'd0, irq}, 32'd1);

        wr_reg(32'h1000_100C, 32'd0);
        rd_check("isr_sticky_ier_off", 32'h1000_1010, 32'h0000_0001);
        wr_reg(32'h1000_1010, 32'h0000_00FF);
        rd_check("isr_final_clear", 32'h1000_1010, 32'd0);
`else
        wr_reg(32'h1000_100C, 32'h0000_00FF);
        rd_check("ier_unmapped", 32'h1000_100C, 32'd0);
        gpio_in = 8'hA4;
        repeat (4) @(negedge PCLK);
        gpio_in = 8'hA5;
        repeat (4) @(negedge PCLK);
        check("irq_tied_low", {31'd0, irq}, 32'd0);
        rd_check("isr_unmapped", 32'h1000_1010, 32'd0);
`endif

        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 32'h1000_1000;
        bus.PWDATA  = 32'h0000_00FF;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        PRESET      = 1'b1;
        @(negedge PCLK);
        check("midrst_pready", {31'd0, bus.PREADY}, 32'd0);
        check("midrst_oe", {24'd0, gpio_oe}, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        check("midrst_prdata", bus.PRDATA, 32'd0);
        rd_check("midrst_cr", 32'h1000_1000, 32'd0);
        rd_check("midrst_odr", 32'h1000_1004, 32'd0);
        wr_reg(32'h1000_1000, 32'h0000_0081);
        rd_check("post_rst_cr", 32'h1000_1000, 32'h0000_0081);
        check("post_rst_oe", {24'd0, gpio_oe}, 32'h81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
